// File: rtl/pipeline_ctrl.sv
// Pipeline stall controller: merges stage stall requests, multi-cycle EX tracking,
// memory wait and a stall watchdog. Optional statistics counters under STALL_STATS_EN.
module pipeline_ctrl #(
  parameter int unsigned TO_W          = 8,
  parameter int unsigned STALL_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        ex_mc_start,
  input  logic [5:0]  ex_mc_len,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [5:0]  stall,
  output logic        ex_mc_busy,
  output logic        ex_mc_done,
  output logic        stall_timeout,
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_bubbles
);

  localparam logic [TO_W-1:0] WD_MAX  = TO_W'(STALL_TIMEOUT);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(STALL_TIMEOUT - 1);

  logic [5:0]      mc_cnt_q, mc_cnt_d;
  logic            ex_mc_done_q, ex_mc_done_d;
  logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            stall_timeout_q, stall_timeout_d;
  logic            mc_start_ok, mc_active, mem_wait, ex_hold;

  always_comb begin
    mc_active   = (mc_cnt_q != '0);
    mc_start_ok = ~rst & ex_mc_start & (ex_mc_len != '0) & ~mc_active;
    mem_wait    = mem_req & ~mem_ack;
    ex_hold     = stallreq_ex | mc_start_ok | mc_active;
    ex_mc_busy  = ~rst & (mc_start_ok | mc_active);

    stall = '0;
    if (rst)              stall = '0;
    else if (mem_wait)    stall = 6'b011111;
    else if (ex_hold)     stall = 6'b001111;
    else if (stallreq_id) stall = 6'b000111;
    else if (stallreq_if) stall = 6'b000011;
  end

  // The counter keeps running under a memory wait: the EX unit computes while held.
  always_comb begin
    mc_cnt_d     = '0;
    ex_mc_done_d = 1'b0;
    if (!rst) begin
      if (mc_start_ok)    mc_cnt_d = ex_mc_len - 6'd1;
      else if (mc_active) mc_cnt_d = mc_cnt_q - 6'd1;
      ex_mc_done_d = (mc_start_ok & (ex_mc_len == 6'd1)) | (mc_cnt_q == 6'd1);
    end
  end

  always_comb begin
    wd_cnt_d        = '0;
    stall_timeout_d = 1'b0;
    if (!rst) begin
      if (stall[0]) wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
      stall_timeout_d = stall_timeout_q | (stall[0] & (wd_cnt_q == WD_LAST));
    end
  end

  always_ff @(posedge clk) begin
    mc_cnt_q        <= mc_cnt_d;
    ex_mc_done_q    <= ex_mc_done_d;
    wd_cnt_q        <= wd_cnt_d;
    stall_timeout_q <= stall_timeout_d;
  end

  assign ex_mc_done    = ex_mc_done_q;
  assign stall_timeout = stall_timeout_q;

`ifdef STALL_STATS_EN
  logic [31:0] stat_stalls_q, stat_stalls_d;
  logic [31:0] stat_bubbles_q, stat_bubbles_d;

  always_comb begin
    stat_stalls_d  = stat_stalls_q + {31'd0, stall[0]};
    stat_bubbles_d = stat_bubbles_q + {31'd0, stall[1] & ~stall[2]};
    if (rst) begin
      stat_stalls_d  = '0;
      stat_bubbles_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stat_stalls_q  <= stat_stalls_d;
    stat_bubbles_q <= stat_bubbles_d;
  end

  assign stat_stalls  = stat_stalls_q;
  assign stat_bubbles = stat_bubbles_q;
`else
  assign stat_stalls  = '0;
  assign stat_bubbles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (STALL_TIMEOUT=200).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_len;
  logic        mem_req, mem_ack;
  logic [5:0]  stall;
  logic        ex_mc_busy, ex_mc_done, stall_timeout;
  logic [31:0] stat_stalls, stat_bubbles;

  int tests_run = 0;
  int tests_failed = 0;

  pipeline_ctrl #(.TO_W(8), .STALL_TIMEOUT(200)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall), .ex_mc_busy(ex_mc_busy), .ex_mc_done(ex_mc_done),
    .stall_timeout(stall_timeout), .stat_stalls(stat_stalls), .stat_bubbles(stat_bubbles)
  );

  always #5 clk = ~clk;

  // One cycle: apply inputs after the falling edge, settle, then the caller checks.
  task automatic cyc(input logic r, input logic i_if, input logic i_id, input logic i_ex,
                     input logic st, input logic [5:0] len, input logic mr, input logic ma);
    @(negedge clk);
    rst = r; stallreq_if = i_if; stallreq_id = i_id; stallreq_ex = i_ex;
    ex_mc_start = st; ex_mc_len = len; mem_req = mr; mem_ack = ma;
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 1, 1, 6'd5, 1, 0);
    cyc(1, 1, 1, 1, 1, 6'd5, 1, 0);
    tests_run++;
    if (stall !== 6'b000000 || ex_mc_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_force stall=%b busy=%b required stall=000000 busy=0", stall, ex_mc_busy);
    end
    cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
    tests_run++;
    if (stall !== 6'b000000 || ex_mc_done !== 1'b0 || stall_timeout !== 1'b0 ||
        ex_mc_busy !== 1'b0 || stat_stalls !== 32'd0 || stat_bubbles !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state stall=%b done=%b to=%b busy=%b ss=%0d sb=%0d required all 0",
               stall, ex_mc_done, stall_timeout, ex_mc_busy, stat_stalls, stat_bubbles);
    end
  endtask

  task automatic test_priority;
    logic [5:0] exp [7];
    logic [31:0] sb0;
    exp = '{6'b000111, 6'b000011, 6'b001111, 6'b011111, 6'b000000, 6'b011111, 6'b000111};
    for (int k = 0; k < 7; k++) begin
      sb0 = stat_bubbles;
      case (k)
        0: cyc(0, 0, 1, 0, 0, 6'd0, 0, 0);
        1: cyc(0, 1, 0, 0, 0, 6'd0, 0, 0);
        2: cyc(0, 0, 0, 1, 0, 6'd0, 0, 0);
        3: cyc(0, 0, 0, 0, 0, 6'd0, 1, 0);
        4: cyc(0, 0, 0, 0, 0, 6'd0, 1, 1);
        5: cyc(0, 1, 1, 1, 0, 6'd0, 1, 0);
        default: cyc(0, 1, 1, 0, 0, 6'd0, 0, 0);
      endcase
      tests_run++;
      if (stall !== exp[k]) begin
        tests_failed++;
        $display("FAIL priority_%0d stall=%b required %b", k, stall, exp[k]);
      end
      cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
      tests_run++;
      if (stall !== 6'b000000) begin
        tests_failed++;
        $display("FAIL priority_idle_%0d stall=%b required 000000", k, stall);
      end
`ifdef STALL_STATS_EN
      if (k == 1) begin
        tests_run++;
        if (stat_bubbles !== sb0 + 32'd1) begin
          tests_failed++;
          $display("FAIL bubble_count got=%0d required %0d", stat_bubbles, sb0 + 32'd1);
        end
      end
`endif
    end
  endtask

  task automatic test_multicycle;
    logic [5:0] exp_st [6];
    logic       exp_bz [6];
    logic       exp_dn [6];
    exp_st = '{6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b000000, 6'b000000};
    exp_bz = '{1, 1, 1, 1, 0, 0};
    exp_dn = '{0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      cyc(0, 0, 0, 0, 1, 6'd4, 0, 0);
      else if (k == 2) cyc(0, 0, 0, 0, 1, 6'd10, 0, 0);
      else             cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
      tests_run++;
      if (stall !== exp_st[k] || ex_mc_busy !== exp_bz[k] || ex_mc_done !== exp_dn[k]) begin
        tests_failed++;
        $display("FAIL mc_len4_t%0d stall=%b busy=%b done=%b required %b %b %b",
                 k, stall, ex_mc_busy, ex_mc_done, exp_st[k], exp_bz[k], exp_dn[k]);
      end
    end
    cyc(0, 0, 0, 0, 1, 6'd1, 0, 0);
    tests_run++;
    if (stall !== 6'b001111 || ex_mc_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mc_len1_t0 stall=%b busy=%b required 001111 1", stall, ex_mc_busy);
    end
    cyc(0, 0, 0, 0, 1, 6'd0, 0, 0);
    tests_run++;
    if (stall !== 6'b000000 || ex_mc_busy !== 1'b0 || ex_mc_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL mc_len1_t1 stall=%b busy=%b done=%b required 000000 0 1",
               stall, ex_mc_busy, ex_mc_done);
    end
    cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
    tests_run++;
    if (ex_mc_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mc_len0_ignored done=%b required 0", ex_mc_done);
    end
  endtask

  task automatic test_mem;
    logic [5:0] exp [3];
    exp = '{6'b011111, 6'b011111, 6'b000111};
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0, 6'd0, 1, (k == 2));
      tests_run++;
      if (stall !== exp[k]) begin
        tests_failed++;
        $display("FAIL mem_wait_%0d stall=%b required %b", k, stall, exp[k]);
      end
    end
    // len-3 op under a 4-cycle memory wait: counter keeps draining underneath
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, (k == 0), 6'd3, (k < 4), 0);
      tests_run++;
      if (stall !== ((k < 4) ? 6'b011111 : 6'b000000) || ex_mc_busy !== (k < 3) ||
          ex_mc_done !== (k == 3)) begin
        tests_failed++;
        $display("FAIL mem_mc_%0d stall=%b busy=%b done=%b", k, stall, ex_mc_busy, ex_mc_done);
      end
    end
  endtask

  task automatic test_watchdog_clear;
    for (int k = 0; k < 399; k++) begin
      cyc(0, 0, 0, (k != 199), 0, 6'd0, 0, 0);
      tests_run++;
      if (stall_timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL wd_clear_cycle%0d timeout=%b required 0", k + 1, stall_timeout);
      end
    end
    cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
    tests_run++;
    if (stall_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_clear_end timeout=%b required 0", stall_timeout);
    end
  endtask

  task automatic test_timeout;
    for (int k = 1; k <= 200; k++) begin
      cyc(0, 0, 0, 1, 0, 6'd0, 0, 0);
      if (k == 200) begin
        tests_run++;
        if (stall_timeout !== 1'b0) begin
          tests_failed++;
          $display("FAIL timeout_early timeout=%b required 0 at cycle 200", stall_timeout);
        end
      end
    end
    for (int k = 201; k <= 205; k++) begin
      cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
      tests_run++;
      if (stall_timeout !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_sticky cycle%0d timeout=%b required 1", k, stall_timeout);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, (k == 1), 6'd20, 0, 0);
    tests_run++;
    if (ex_mc_busy !== 1'b1 || stall !== 6'b001111) begin
      tests_failed++;
      $display("FAIL rstmid_pre busy=%b stall=%b required 1 001111", ex_mc_busy, stall);
    end
    cyc(1, 0, 0, 0, 0, 6'd0, 0, 0);
    tests_run++;
    if (ex_mc_busy !== 1'b0 || stall !== 6'b000000) begin
      tests_failed++;
      $display("FAIL rstmid_during busy=%b stall=%b required 0 000000", ex_mc_busy, stall);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0, 6'd0, 0, 0);
      tests_run++;
      if (ex_mc_busy !== 1'b0 || stall !== 6'b000000 || ex_mc_done !== 1'b0 ||
          stall_timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_after_%0d busy=%b stall=%b done=%b to=%b required 0 000000 0 0",
                 k, ex_mc_busy, stall, ex_mc_done, stall_timeout);
      end
    end
`ifndef STALL_STATS_EN
    tests_run++;
    if (stat_stalls !== 32'd0 || stat_bubbles !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_tied ss=%0d sb=%0d required 0 0", stat_stalls, stat_bubbles);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0;
    ex_mc_start = 0; ex_mc_len = '0; mem_req = 0; mem_ack = 0;
    test_reset();
    test_priority();
    test_multicycle();
    test_mem();
    test_watchdog_clear();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
